usb_serial_bridge: RTL

Memory-mapped byte-stream bridge between the 4-register bus slave port used by the USB peripheral and a USB serial (CDC) device core. It adds parametrised TX and RX FIFOs, FIFO levels, sticky overflow flags, flush controls and a level-driven interrupt. It sits between the bus decoder and the serial device core's byte interface, and replaces direct single-byte register coupling.

---
 rtl/usb_serial_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/usb_serial_bridge.sv
// usb_serial_bridge: memory-mapped byte-stream bridge between a 4-register bus
// slave port and a USB CDC device core byte interface, with TX/RX FIFOs,
// FIFO levels, sticky overflow flags, flush controls and a level interrupt.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   write_i, read_i          bus access strobes (one cycle each, mutually exclusive)
//   data_be_i, addr_i        byte enables (bit 0 gates writes), register select addr_i[3:2]
//   wdata_i, rdata_o         write data, registered read data (1-cycle latency)
//   irq_o                    registered interrupt
//   dev_connected_i          device core enumerated/configured
//   dev_rx_data_i/valid_i    byte strobe from the host (no backpressure)
//   dev_tx_data_o/valid_o    TX FIFO head towards the host
//   dev_tx_ready_i           device core accepts the TX head
module usb_serial_bridge #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [3:0]  data_be_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    input  logic        dev_connected_i,
    input  logic [7:0]  dev_rx_data_i,
    input  logic        dev_rx_valid_i,
    output logic [7:0]  dev_tx_data_o,
    output logic        dev_tx_valid_o,
    input  logic        dev_tx_ready_i
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_LW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_LW = RX_AW + 1;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_RDR  = 2'd1;
    localparam logic [1:0] ADDR_TDR  = 2'd2;
    localparam logic [1:0] ADDR_STA  = 2'd3;

    // Control and status state
    logic en_q, rx_irq_en_q, tx_irq_en_q;
    logic rx_ovf_q, tx_ovf_q;
    logic conn_q, disc_q;

    // FIFO state
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_LW-1:0] tx_level;
    logic [RX_LW-1:0] rx_level;

    // Bus decode
    logic [1:0] sel_c;
    logic       wr_en_c, ctrl_wr_c, tdr_wr_c, sta_wr_c, rdr_rd_c;
    logic       tx_full_c, rx_full_c, tx_empty_c, rx_empty_c;
    logic       tx_flush_c, rx_flush_c;
    logic       tx_push_c, tx_pop_c, tx_drop_c;
    logic       rx_push_c, rx_pop_c, rx_drop_c;
    logic [31:0] rd_data_c;

    logic unused_bits;
    assign unused_bits = ^{data_be_i[3:1], addr_i[1:0], wdata_i[31:8]};

    assign sel_c     = addr_i[3:2];
    assign wr_en_c   = write_i && data_be_i[0];
    assign ctrl_wr_c = wr_en_c && (sel_c == ADDR_CTRL);
    assign tdr_wr_c  = wr_en_c && (sel_c == ADDR_TDR);
    assign sta_wr_c  = wr_en_c && (sel_c == ADDR_STA);
    assign rdr_rd_c  = read_i && (sel_c == ADDR_RDR);

    assign tx_full_c  = (tx_level == TX_LW'(TX_DEPTH));
    assign rx_full_c  = (rx_level == RX_LW'(RX_DEPTH));
    assign tx_empty_c = (tx_level == '0);
    assign rx_empty_c = (rx_level == '0);

    // Disconnect flush is a registered pulse one cycle after the registered falling edge
    assign tx_flush_c = (ctrl_wr_c && wdata_i[1]) || disc_q;
    assign rx_flush_c = (ctrl_wr_c && wdata_i[2]) || disc_q;

    // Acceptance uses the level before the edge; a same-cycle pop never makes room
    assign tx_push_c = tdr_wr_c && !tx_full_c && !tx_flush_c;
    assign tx_drop_c = tdr_wr_c && tx_full_c;
    assign tx_pop_c  = dev_tx_valid_o && dev_tx_ready_i && !tx_flush_c;

    assign rx_push_c = dev_rx_valid_i && en_q && !rx_full_c && !rx_flush_c;
    assign rx_drop_c = dev_rx_valid_i && en_q && rx_full_c;
    assign rx_pop_c  = rdr_rd_c && !rx_empty_c && !rx_flush_c;

    assign dev_tx_valid_o = en_q && !tx_empty_c;
    // Gated by level so the unreset memory never leaks out after reset or flush
    assign dev_tx_data_o  = tx_empty_c ? 8'h00 : tx_mem[tx_rd_ptr];

    // Read data mux, captured on read_i
    always_comb begin
        rd_data_c = 32'h0;
        case (sel_c)
            ADDR_CTRL: rd_data_c = {27'h0, tx_irq_en_q, rx_irq_en_q, 2'b00, en_q};
            ADDR_RDR:  rd_data_c = rx_empty_c ? 32'h0 : {23'h0, 1'b1, rx_mem[rx_rd_ptr]};
            ADDR_TDR:  rd_data_c = 32'h0;
            ADDR_STA:  rd_data_c = {8'h00, 8'(tx_level), 8'(rx_level), 3'b000,
                                    tx_ovf_q, rx_ovf_q, tx_full_c, !rx_empty_c,
                                    dev_connected_i};
            default:   rd_data_c = 32'h0;
        endcase
    end

    // FIFO storage (contents need no reset)
    always_ff @(posedge clk_i) begin
        if (tx_push_c) tx_mem[tx_wr_ptr] <= wdata_i[7:0];
        if (rx_push_c) rx_mem[rx_wr_ptr] <= dev_rx_data_i;
    end

    // TX pointers and level
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else if (tx_flush_c) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push_c && !tx_pop_c)      tx_level <= tx_level + TX_LW'(1);
            else if (!tx_push_c && tx_pop_c) tx_level <= tx_level - TX_LW'(1);
        end
    end

    // RX pointers and level
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else if (rx_flush_c) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_push_c && !rx_pop_c)      rx_level <= rx_level + RX_LW'(1);
            else if (!rx_push_c && rx_pop_c) rx_level <= rx_level - RX_LW'(1);
        end
    end

    // Control, sticky flags (set wins over W1C), disconnect detect, read data, interrupt
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q        <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            conn_q      <= 1'b0;
            disc_q      <= 1'b0;
            rdata_o     <= 32'h0;
            irq_o       <= 1'b0;
        end else begin
            if (ctrl_wr_c) begin
                en_q        <= wdata_i[0];
                rx_irq_en_q <= wdata_i[3];
                tx_irq_en_q <= wdata_i[4];
            end
            if (rx_drop_c)                    rx_ovf_q <= 1'b1;
            else if (sta_wr_c && wdata_i[3])  rx_ovf_q <= 1'b0;
            if (tx_drop_c)                    tx_ovf_q <= 1'b1;
            else if (sta_wr_c && wdata_i[4])  tx_ovf_q <= 1'b0;
            conn_q <= dev_connected_i;
            disc_q <= conn_q && !dev_connected_i;
            if (read_i) rdata_o <= rd_data_c;
            irq_o <= (rx_irq_en_q && !rx_empty_c) || (tx_irq_en_q && tx_empty_c) ||
                     rx_ovf_q || tx_ovf_q;
        end
    end

endmodule
